// File: rtl/cal1d_pool_lanes.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cal1d_pool_lanes
// Purpose  : Multi-lane 1-D pooling engine. Accumulates a window of
//            1..KW_MAX input beats per lane with SUM (saturating), MAX or
//            MIN and emits one result beat per window through a single
//            registered output stage with backpressure.
// Ports    : nvdla_core_clk / nvdla_core_rstn - clock, async active-low reset
//            cfg_pool_method  - 0=SUM 1=MAX 2=MIN 3=SUM
//            cfg_kernel_width - window length minus one
//            inp_pvld/inp_prdy/inp_pd - input beat handshake, LANES x DATA_W
//            out_pvld/out_prdy/out_pd - result handshake, LANES x ACC_W
//            out_cnt          - beats contained in the emitted window
// Revision : 1.0 - initial release
// ============================================================================
module cal1d_pool_lanes #(
  parameter int LANES  = 4,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 19,
  parameter int KW_MAX = 8
) (
  input  logic                        nvdla_core_clk,
  input  logic                        nvdla_core_rstn,
  input  logic [1:0]                  cfg_pool_method,
  input  logic [$clog2(KW_MAX)-1:0]   cfg_kernel_width,
  input  logic                        inp_pvld,
  output logic                        inp_prdy,
  input  logic [LANES*DATA_W-1:0]     inp_pd,
  output logic                        out_pvld,
  input  logic                        out_prdy,
  output logic [LANES*ACC_W-1:0]      out_pd,
  output logic [$clog2(KW_MAX):0]     out_cnt
);

  localparam int KW_W  = $clog2(KW_MAX);
  localparam int CNT_W = KW_W + 1;
  localparam logic [1:0] METH_MAX = 2'd1;
  localparam logic [1:0] METH_MIN = 2'd2;
  localparam logic signed [ACC_W-1:0] ACC_POS = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_NEG = {1'b1, {(ACC_W-1){1'b0}}};

  logic [KW_W-1:0]        cnt;
  logic [KW_W-1:0]        kw_l;
  logic [KW_W-1:0]        kw_eff;
  logic [1:0]             meth_l;
  logic [LANES*ACC_W-1:0] acc;
  logic [LANES*ACC_W-1:0] acc_nxt;
  logic                   first_beat;
  logic                   last_beat;
  logic                   accept;

  // The first beat of a window uses the live kernel width, since the latched
  // copy still belongs to the previous window.
  assign first_beat = (cnt == '0);
  assign kw_eff     = first_beat ? cfg_kernel_width : kw_l;
  assign last_beat  = (cnt == kw_eff);
  assign inp_prdy   = !last_beat | !out_pvld | out_prdy;
  assign accept     = inp_pvld & inp_prdy;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [DATA_W-1:0] din;
    logic signed [ACC_W-1:0]  din_ext;
    logic signed [ACC_W-1:0]  acc_cur;
    logic signed [ACC_W:0]    sum;
    logic signed [ACC_W-1:0]  res;

    assign din     = inp_pd[i*DATA_W +: DATA_W];
    assign din_ext = ACC_W'(din);
    assign acc_cur = acc[i*ACC_W +: ACC_W];
    // One guard bit: overflow shows up as disagreement of the top two bits.
    assign sum     = (ACC_W+1)'(acc_cur) + (ACC_W+1)'(din_ext);

    always_comb begin
      res = acc_cur;
      if (first_beat) begin
        res = din_ext;
      end else begin
        case (meth_l)
          METH_MAX: res = (din_ext > acc_cur) ? din_ext : acc_cur;
          METH_MIN: res = (din_ext < acc_cur) ? din_ext : acc_cur;
          default: begin
            if (sum[ACC_W] != sum[ACC_W-1]) res = sum[ACC_W] ? ACC_NEG : ACC_POS;
            else                            res = sum[ACC_W-1:0];
          end
        endcase
      end
    end

    assign acc_nxt[i*ACC_W +: ACC_W] = res;
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      cnt      <= '0;
      kw_l     <= '0;
      meth_l   <= '0;
      acc      <= '0;
      out_pvld <= 1'b0;
      out_pd   <= '0;
      out_cnt  <= '0;
    end else begin
      if (accept) begin
        acc <= acc_nxt;
        cnt <= last_beat ? '0 : cnt + 1'b1;
        if (first_beat) begin
          kw_l   <= cfg_kernel_width;
          meth_l <= cfg_pool_method;
        end
      end
      // A completing window reloads the register even while it drains.
      if (accept && last_beat) begin
        out_pvld <= 1'b1;
        out_pd   <= acc_nxt;
        out_cnt  <= {1'b0, kw_eff} + CNT_W'(1);
      end else if (out_prdy) begin
        out_pvld <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cal1d_pool_lanes.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cal1d_pool_lanes
// Purpose  : Directed scoreboard bench for cal1d_pool_lanes. Two instances
//            (ACC_W=19 and ACC_W=17) share all inputs; a behavioural model
//            predicts handshakes and per-window results for both widths.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cal1d_pool_lanes;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  meth;
  logic [2:0]  kw;
  logic        pvld;
  logic [63:0] pd;
  logic        out_prdy;

  logic        prdy_a, pvld_a, prdy_b, pvld_b;
  logic [75:0] opd_a;
  logic [67:0] opd_b;
  logic [3:0]  ocnt_a, ocnt_b;

  always #5 clk = ~clk;

  cal1d_pool_lanes #(.LANES(4), .DATA_W(16), .ACC_W(19), .KW_MAX(8)) dut_a (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rst_n),
    .cfg_pool_method(meth), .cfg_kernel_width(kw),
    .inp_pvld(pvld), .inp_prdy(prdy_a), .inp_pd(pd),
    .out_pvld(pvld_a), .out_prdy(out_prdy), .out_pd(opd_a), .out_cnt(ocnt_a)
  );

  cal1d_pool_lanes #(.LANES(4), .DATA_W(16), .ACC_W(17), .KW_MAX(8)) dut_b (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rst_n),
    .cfg_pool_method(meth), .cfg_kernel_width(kw),
    .inp_pvld(pvld), .inp_prdy(prdy_b), .inp_pd(pd),
    .out_pvld(pvld_b), .out_prdy(out_prdy), .out_pd(opd_b), .out_cnt(ocnt_b)
  );

  typedef struct {
    logic [75:0] pd_a;
    logic [67:0] pd_b;
    logic [3:0]  cnt;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          m_cnt, m_kw;
  logic [1:0]  m_meth;
  bit          m_vld;
  longint      acc_a[4], acc_b[4];
  logic [75:0] last_a;
  logic [67:0] last_b;
  logic [3:0]  last_cnt;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint sat(input longint v, input int w);
    longint hi, lo;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_kw = 0; m_meth = 2'd0; m_vld = 1'b0;
    sb.delete();
    for (int i = 0; i < 4; i++) begin acc_a[i] = 0; acc_b[i] = 0; end
  endtask

  // Model one accepted beat; reports whether the window completed.
  task automatic model_beat(output bit comp);
    int     kwe;
    longint x;
    logic [63:0] t;
    exp_t   e;
    kwe = (m_cnt == 0) ? int'(kw) : m_kw;
    if (m_cnt == 0) begin m_kw = int'(kw); m_meth = meth; end
    for (int i = 0; i < 4; i++) begin
      x = longint'($signed(pd[i*16 +: 16]));
      if (m_cnt == 0) begin
        acc_a[i] = x; acc_b[i] = x;
      end else if (m_meth == 2'd1) begin
        if (x > acc_a[i]) acc_a[i] = x;
        if (x > acc_b[i]) acc_b[i] = x;
      end else if (m_meth == 2'd2) begin
        if (x < acc_a[i]) acc_a[i] = x;
        if (x < acc_b[i]) acc_b[i] = x;
      end else begin
        acc_a[i] = sat(acc_a[i] + x, 19);
        acc_b[i] = sat(acc_b[i] + x, 17);
      end
    end
    comp = 1'b0;
    if (m_cnt == kwe) begin
      for (int i = 0; i < 4; i++) begin
        t = acc_a[i]; e.pd_a[i*19 +: 19] = t[18:0];
        t = acc_b[i]; e.pd_b[i*17 +: 17] = t[16:0];
      end
      e.cnt = 4'(kwe + 1);
      sb.push_back(e);
      m_cnt = 0;
      comp  = 1'b1;
    end else begin
      m_cnt++;
    end
  endtask

  // One clock cycle, entered at a falling edge with inputs already driven.
  task automatic cycle(output bit accepted);
    bit exp_prdy, comp, drain;
    #1;
    exp_prdy = (m_cnt != ((m_cnt == 0) ? int'(kw) : m_kw)) || !m_vld || out_prdy;
    chk("inp_prdy_a", 128'(prdy_a), 128'(exp_prdy));
    chk("inp_prdy_b", 128'(prdy_b), 128'(exp_prdy));
    chk("out_pvld_a", 128'(pvld_a), 128'(m_vld));
    chk("out_pvld_b", 128'(pvld_b), 128'(m_vld));
    if (m_vld && sb.size() > 0) begin
      chk("out_pd_a",  128'(opd_a),  128'(sb[0].pd_a));
      chk("out_pd_b",  128'(opd_b),  128'(sb[0].pd_b));
      chk("out_cnt_a", 128'(ocnt_a), 128'(sb[0].cnt));
      chk("out_cnt_b", 128'(ocnt_b), 128'(sb[0].cnt));
      if (out_prdy) begin
        last_a = opd_a; last_b = opd_b; last_cnt = ocnt_a;
        void'(sb.pop_front());
      end
    end
    drain    = m_vld && out_prdy;
    accepted = pvld && exp_prdy;
    comp     = 1'b0;
    if (accepted) model_beat(comp);
    m_vld = comp ? 1'b1 : (drain ? 1'b0 : m_vld);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input int l0, input int l1, input int l2, input int l3);
    bit a;
    a    = 1'b0;
    pd   = {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
    pvld = 1'b1;
    for (int n = 0; n < 20 && !a; n++) cycle(a);
    if (!a) chk("send_timeout", 128'(a), 128'(1'b1));
  endtask

  task automatic idle(input int n);
    bit a;
    pvld = 1'b0;
    for (int k = 0; k < n; k++) cycle(a);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_pvld_a", 128'(pvld_a), 128'(0));
    chk("rst_pvld_b", 128'(pvld_b), 128'(0));
    chk("rst_pd_a",   128'(opd_a),  128'(0));
    chk("rst_pd_b",   128'(opd_b),  128'(0));
    chk("rst_cnt_a",  128'(ocnt_a), 128'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit a;
    rst_n = 1'b1; pvld = 1'b0; pd = '0; meth = 2'd0; kw = 3'd0; out_prdy = 1'b1;
    last_a = '0; last_b = '0; last_cnt = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    // 4-beat SUM window
    kw = 3'd3; meth = 2'd0;
    send(1, 100, -1, -5); send(2, 200, -2, -5); send(3, 300, -3, -5); send(4, 400, -4, -5);
    idle(2);
    chk("t1_lane0", 128'(last_a[18:0]),  128'(19'd10));
    chk("t1_lane3", 128'(last_a[75:57]), 128'(19'h7FFEC));
    chk("t1_cnt",   128'(last_cnt),      128'(4'd4));

    // MAX then MIN over a 3-beat window
    kw = 3'd2; meth = 2'd1;
    send(0, -3, 5, 9); send(1, 7, -5, 9); send(2, -32768, 4, -9);
    idle(2);
    chk("t2_max", 128'(last_a[37:19]), 128'(19'd7));
    meth = 2'd2;
    send(0, -3, 5, 9); send(1, 7, -5, 9); send(2, -32768, 4, -9);
    idle(2);
    chk("t2_min", 128'(last_a[37:19]), 128'(19'h78000));

    // Saturating SUM (17-bit instance) over 8 beats; reserved method 3 on the negative run
    kw = 3'd7; meth = 2'd0;
    for (int n = 0; n < 8; n++) send(32767, 32767, 32767, 32767);
    idle(2);
    chk("t3_pos_b", 128'(last_b[16:0]), 128'(17'h0FFFF));
    chk("t3_pos_a", 128'(last_a[18:0]), 128'(19'h3FFF8));
    meth = 2'd3;
    for (int n = 0; n < 8; n++) send(-32768, -32768, -32768, -32768);
    idle(2);
    chk("t3_neg_b", 128'(last_b[67:51]), 128'(17'h10000));
    chk("t3_neg_a", 128'(last_a[75:57]), 128'(19'h40000));

    // Backpressure with 2-beat windows
    kw = 3'd1; meth = 2'd0; out_prdy = 1'b0;
    send(10, 20, 30, 40); send(1, 1, 1, 1);
    send(100, -1, 0, 7);
    pd = {16'(4), 16'(3), 16'(2), 16'(-50)};
    pvld = 1'b1;
    cycle(a); chk("t4_stall0", 128'(a), 128'(1'b0));
    cycle(a); chk("t4_stall1", 128'(a), 128'(1'b0));
    out_prdy = 1'b1;
    cycle(a); chk("t4_release", 128'(a), 128'(1'b1));
    idle(2);
    chk("t4_lane0", 128'(last_a[18:0]), 128'(19'd50));

    // Single-beat windows at full rate
    kw = 3'd0; meth = 2'd2;
    send(5, 5, 5, 5); send(6, 6, 6, 6); send(7, 7, 7, 7);
    idle(2);
    chk("t5_last", 128'(last_a[18:0]), 128'(19'd7));

    // Partial window discarded by reset, then a window with a mid-window method change
    kw = 3'd3; meth = 2'd0;
    send(1, 1, 1, 1); meth = 2'd1; send(2, 2, 2, 2);
    pvld = 1'b0;
    do_reset();
    meth = 2'd0;
    send(10, -1, 0, 3); meth = 2'd1;
    send(20, -1, 0, 3); send(30, -1, 0, 3); send(40, -1, 0, 3);
    idle(2);
    chk("t6_lane0", 128'(last_a[18:0]), 128'(19'd100));
    chk("t6_lane1", 128'(last_a[37:19]), 128'(19'h7FFFC));
    chk("t6_cnt",   128'(last_cnt), 128'(4'd4));
    chk("sb_drained", 128'(sb.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
